raw10_unpacker: RTL and testbench

Pixel-formatting stage directly downstream of the CSI-2 packet handler. Consumes the 16-bit payload stream of RAW10 long packets (data type 0x2B) plus the frame-start pulse, and unpacks each 5-byte RAW10 group into 10-bit pixels, emitted two per cycle with frame and line markers. Output feeds the ISP / frame-buffer writer.

---
 rtl/raw10_unpacker_if.sv | 33 +++
 rtl/raw10_unpacker.sv | 163 ++++++++++++++++
 tb/tb_raw10_unpacker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/raw10_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : raw10_unpacker_if
//  Description : Payload stream in / pixel-pair stream out of the RAW10
//                unpacker. The master drives the payload stream, the slave
//                (the unpacker) drives the pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface raw10_unpacker_if #(
    parameter int LINE_W = 12
) ();
    logic              raw_vld;
    logic [15:0]       raw_data;
    logic              raw_vsync;
    logic              pix_vld;
    logic [19:0]       pix_data;
    logic              pix_fs;
    logic              pix_sol;
    logic              pix_eol;
    logic [LINE_W-1:0] line_cnt;
    logic              line_err;

    modport master (
        output raw_vld, raw_data, raw_vsync,
        input  pix_vld, pix_data, pix_fs, pix_sol, pix_eol, line_cnt, line_err
    );

    modport slave (
        input  raw_vld, raw_data, raw_vsync,
        output pix_vld, pix_data, pix_fs, pix_sol, pix_eol, line_cnt, line_err
    );
endinterface
`default_nettype wire

// File: rtl/raw10_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : raw10_unpacker
//  Description : Unpacks CSI-2 RAW10 payload words (16 bit, low byte first)
//                into 10-bit pixel pairs with frame/line markers and a line
//                counter. Five words carry two 5-byte groups (8 pixels).
//  Revision    : 1.0 - initial release
// ============================================================================
module raw10_unpacker #(
    parameter int LINE_W = 12
) (
    input  logic            clk,
    input  logic            resetn,
    raw10_unpacker_if.slave bus
);

    localparam logic [2:0] c_PH_MAX = 3'd4;

    // Word/group tracking
    logic [2:0]        r_phase;
    logic [7:0]        r_b0, r_b1, r_b2, r_b3;
    logic [19:0]       r_pend;
    logic              r_flush;
    logic              r_vld_d;
    logic              r_hold;      // ignore a packet already in flight at reset release
    logic              r_sol_arm;
    logic              r_inc;

    // Registered outputs
    logic              r_pix_vld;
    logic [19:0]       r_pix_data;
    logic              r_pix_fs;
    logic              r_pix_sol;
    logic              r_pix_eol;
    logic [LINE_W-1:0] r_line_cnt;
    logic              r_line_err;

    logic [7:0]        w_lo, w_hi;
    logic              w_vld, w_rise, w_emit, w_eol, w_err;
    logic [19:0]       w_pair;

    // Select the pair to emit this cycle and classify line boundaries
    always_comb begin
        w_lo   = bus.raw_data[7:0];
        w_hi   = bus.raw_data[15:8];
        w_vld  = bus.raw_vld & ~r_hold;
        w_rise = w_vld & ~r_vld_d;
        w_emit = 1'b0;
        w_pair = '0;
        // The flush cycle always coincides with phase 0 of the next word,
        // which never emits, so the two sources cannot collide.
        if (r_flush) begin
            w_emit = 1'b1;
            w_pair = r_pend;
        end else if (w_vld) begin
            case (r_phase)
                3'd2: begin
                    w_emit = 1'b1;
                    w_pair = {r_b1, w_lo[3:2], r_b0, w_lo[1:0]};
                end
                3'd3: begin
                    w_emit = 1'b1;
                    w_pair = r_pend;
                end
                3'd4: begin
                    w_emit = 1'b1;
                    w_pair = {r_b1, w_hi[3:2], r_b0, w_hi[1:0]};
                end
                default: ;
            endcase
        end
        w_eol = r_flush & ~w_vld;
        w_err = r_vld_d & ~w_vld & (r_phase != 3'd0);
    end

    // Byte collection, phase tracking and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_phase    <= 3'd0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_b3       <= '0;
            r_pend     <= '0;
            r_flush    <= 1'b0;
            r_vld_d    <= 1'b0;
            r_hold     <= 1'b1;
            r_sol_arm  <= 1'b0;
            r_inc      <= 1'b0;
            r_pix_vld  <= 1'b0;
            r_pix_data <= '0;
            r_pix_fs   <= 1'b0;
            r_pix_sol  <= 1'b0;
            r_pix_eol  <= 1'b0;
            r_line_cnt <= '0;
            r_line_err <= 1'b0;
        end else begin
            r_vld_d <= w_vld;
            r_hold  <= r_hold & bus.raw_vld;
            r_flush <= w_vld & (r_phase == c_PH_MAX);

            if (!w_vld || r_phase == c_PH_MAX) begin
                r_phase <= 3'd0;
            end else begin
                r_phase <= r_phase + 3'd1;
            end

            if (w_vld) begin
                case (r_phase)
                    3'd0: begin
                        r_b0 <= w_lo;
                        r_b1 <= w_hi;
                    end
                    3'd1: begin
                        r_b2 <= w_lo;
                        r_b3 <= w_hi;
                    end
                    3'd2: begin
                        r_pend <= {r_b3, w_lo[7:6], r_b2, w_lo[5:4]};
                        r_b0   <= w_hi;
                    end
                    3'd3: begin
                        r_b1 <= w_lo;
                        r_b2 <= w_hi;
                    end
                    3'd4: begin
                        r_pend <= {w_lo, w_hi[7:6], r_b2, w_hi[5:4]};
                    end
                    default: ;
                endcase
            end

            r_pix_vld <= w_emit;
            if (w_emit) begin
                r_pix_data <= w_pair;
            end
            r_pix_sol  <= w_emit & r_sol_arm;
            r_sol_arm  <= w_rise | (r_sol_arm & ~w_emit);
            r_pix_eol  <= w_eol;
            r_line_err <= w_err;
            r_pix_fs   <= bus.raw_vsync;

            // A frame start seen together with the closing flush cancels the
            // increment that would otherwise follow the end-of-line pair.
            r_inc <= w_eol & ~bus.raw_vsync;
            if (bus.raw_vsync) begin
                r_line_cnt <= '0;
            end else if (r_inc) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

    assign bus.pix_vld  = r_pix_vld;
    assign bus.pix_data = r_pix_data;
    assign bus.pix_fs   = r_pix_fs;
    assign bus.pix_sol  = r_pix_sol;
    assign bus.pix_eol  = r_pix_eol;
    assign bus.line_cnt = r_line_cnt;
    assign bus.line_err = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_raw10_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raw10_unpacker
//  Description : Scoreboard bench for raw10_unpacker. Expected pixel pairs
//                are derived from the payload bytes and queued when words
//                are driven; the monitor pops them as pairs appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_raw10_unpacker;

    localparam int LINE_W = 12;

    typedef struct packed {
        logic [19:0] data;
        logic        sol;
        logic        eol;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;

    raw10_unpacker_if #(.LINE_W(LINE_W)) bus ();

    raw10_unpacker #(.LINE_W(LINE_W)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] wq[$];
    exp_t        mon_e;
    int          n_total  = 0;
    int          n_bad    = 0;
    int          err_seen = 0;
    int          err_exp  = 0;
    int          exp_cnt  = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [9:0] even, input logic [9:0] odd,
                                input logic sol, input logic eol);
        exp_t e;
        e.data = {odd, even};
        e.sol  = sol;
        e.eol  = eol;
        return e;
    endfunction

    // Pop and compare every emitted pair; count line_err pulses
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.line_err) err_seen++;
            if (bus.pix_vld) begin
                if (exp_q.size() == 0) begin
                    check("pair_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_data", 32'(bus.pix_data), 32'(mon_e.data));
                    check("pix_sol",  32'(bus.pix_sol),  32'(mon_e.sol));
                    check("pix_eol",  32'(bus.pix_eol),  32'(mon_e.eol));
                end
            end else begin
                check("marker_idle", 32'({bus.pix_sol, bus.pix_eol}), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"},  32'(bus.pix_vld),  32'd0);
        check({tag, "_data"}, 32'(bus.pix_data), 32'd0);
        check({tag, "_fs"},   32'(bus.pix_fs),   32'd0);
        check({tag, "_sol"},  32'(bus.pix_sol),  32'd0);
        check({tag, "_eol"},  32'(bus.pix_eol),  32'd0);
        check({tag, "_cnt"},  32'(bus.line_cnt), 32'd0);
        check({tag, "_err"},  32'(bus.line_err), 32'd0);
    endtask

    task automatic do_vsync();
        @(negedge clk);
        bus.raw_vsync = 1'b1;
        @(negedge clk);
        bus.raw_vsync = 1'b0;
        check("pix_fs", 32'(bus.pix_fs), 32'd1);
        check("cnt_after_vsync", 32'(bus.line_cnt), 32'd0);
        exp_cnt = 0;
    endtask

    task automatic idle_chk(input int n);
        repeat (n) @(negedge clk);
        check("line_cnt_idle", 32'(bus.line_cnt), 32'(exp_cnt));
    endtask

    // Drive the words in wq as one line, optionally queueing model pairs
    task automatic send_line(input int gap, input bit chk, input bit use_model, input bit vs_flush);
        int          nw;
        int          np;
        int          r;
        int          base;
        logic [15:0] w;
        logic [7:0]  b[];
        logic [7:0]  b4;
        exp_t        e;
        nw = wq.size();
        r  = nw % 5;
        if (use_model) begin
            b = new[2 * nw];
            for (int i = 0; i < nw; i++) begin
                w          = wq[i];
                b[2*i]     = w[7:0];
                b[2*i + 1] = w[15:8];
            end
            np = (nw / 5) * 4 + ((r >= 3) ? 1 : 0) + ((r >= 4) ? 1 : 0);
            for (int k = 0; k < np; k++) begin
                base = 5 * (k / 2);
                b4   = b[base + 4];
                if (k % 2 == 0)
                    e = mk({b[base],     b4[1:0]}, {b[base + 1], b4[3:2]}, 1'b0, 1'b0);
                else
                    e = mk({b[base + 2], b4[5:4]}, {b[base + 3], b4[7:6]}, 1'b0, 1'b0);
                e.sol = (k == 0);
                e.eol = (k == np - 1) && (r == 0);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            if (i == 0 && chk) check("line_cnt", 32'(bus.line_cnt), 32'(exp_cnt));
            bus.raw_vld  = 1'b1;
            bus.raw_data = wq[i];
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == 1 && vs_flush) check("fs_at_flush", 32'(bus.pix_fs), 32'd1);
            bus.raw_vld   = 1'b0;
            bus.raw_data  = 16'($urandom);
            bus.raw_vsync = (g == 0) && vs_flush;
        end
        bus.raw_vsync = 1'b0;
        if (r != 0)        err_exp++;
        else if (vs_flush) exp_cnt = 0;
        else               exp_cnt = (exp_cnt + 1) % (1 << LINE_W);
        wq.delete();
    endtask

    task automatic fill_random(input int nw);
        for (int i = 0; i < nw; i++) wq.push_back(16'($urandom));
    endtask

    int prev_gap;
    int gap;

    initial begin
        resetn        = 1'b0;
        bus.raw_vld   = 1'b0;
        bus.raw_data  = 16'h0;
        bus.raw_vsync = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        resetn = 1'b1;
        mon_en = 1'b1;

        // Basic line with hand-computed pixels
        do_vsync();
        wq = '{16'h2211, 16'h4433, 16'h55E4, 16'h7766, 16'h1B88};
        exp_q.push_back(mk(10'h044, 10'h089, 1'b1, 1'b0));
        exp_q.push_back(mk(10'h0CE, 10'h113, 1'b0, 1'b0));
        exp_q.push_back(mk(10'h157, 10'h19A, 1'b0, 1'b0));
        exp_q.push_back(mk(10'h1DD, 10'h220, 1'b0, 1'b1));
        send_line(3, 1'b1, 1'b0, 1'b0);
        idle_chk(1);

        // Multi-line frame, then a new frame resets the count
        do_vsync();
        for (int l = 0; l < 3; l++) begin
            fill_random(20);
            send_line(2, 1'b1, 1'b1, 1'b0);
        end
        idle_chk(2);
        do_vsync();

        // Short line: one pair, error pulse, no end of line
        wq = '{16'h2211, 16'h4433, 16'h55E4};
        exp_q.push_back(mk(10'h044, 10'h089, 1'b1, 1'b0));
        send_line(3, 1'b1, 1'b0, 1'b0);
        check("short_err", 32'(err_seen), 32'(err_exp));
        fill_random(5);
        send_line(3, 1'b1, 1'b1, 1'b0);
        idle_chk(1);

        // Back-to-back lines with a single idle cycle
        fill_random(5);
        send_line(1, 1'b1, 1'b1, 1'b0);
        fill_random(5);
        send_line(3, 1'b0, 1'b1, 1'b0);
        idle_chk(1);

        // Frame start coincident with the closing flush
        fill_random(10);
        send_line(3, 1'b1, 1'b1, 1'b1);
        idle_chk(2);

        // Reset while the phase-3 word is presented
        wq = '{16'h2211, 16'h4433, 16'h55E4};
        exp_q.push_back(mk(10'h044, 10'h089, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.raw_vld  = 1'b1;
            bus.raw_data = wq[i];
        end
        wq.delete();
        @(negedge clk);
        bus.raw_data = 16'h7766;
        resetn       = 1'b0;
        @(negedge clk);
        resetn      = 1'b1;
        bus.raw_vld = 1'b0;
        check_all_zero("mid_rst");
        exp_cnt = 0;
        wq = '{16'h2211, 16'h4433, 16'h55E4, 16'h7766, 16'h1B88};
        exp_q.push_back(mk(10'h044, 10'h089, 1'b1, 1'b0));
        exp_q.push_back(mk(10'h0CE, 10'h113, 1'b0, 1'b0));
        exp_q.push_back(mk(10'h157, 10'h19A, 1'b0, 1'b0));
        exp_q.push_back(mk(10'h1DD, 10'h220, 1'b0, 1'b1));
        send_line(3, 1'b1, 1'b0, 1'b0);
        idle_chk(1);

        // Random whole-group lines against the byte-level model
        do_vsync();
        prev_gap = 3;
        for (int l = 0; l < 60; l++) begin
            fill_random(5 * $urandom_range(1, 20));
            gap = $urandom_range(1, 4);
            send_line(gap, prev_gap >= 2, 1'b1, 1'b0);
            prev_gap = gap;
        end

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("line_err_total", 32'(err_seen), 32'(err_exp));
        check("line_cnt_final", 32'(bus.line_cnt), 32'(exp_cnt));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
